// File: rtl/b2a_pkg.sv
// Shared constants and types for the 3-share Boolean-to-arithmetic
// output stage.
package b2a_pkg;

    localparam int K_WIDTH  = 32;
    localparam int N_SHARES = 3;
    localparam int DEPTH    = 2;

    typedef logic [K_WIDTH-1:0] share_t;
    typedef logic [$clog2(DEPTH+1)-1:0] cnt_t;

endpackage

// File: rtl/b2a_fifo2.sv
// Two-entry synchronous FIFO with occupancy count.
// Reads come straight from the storage registers.
module b2a_fifo2
    import b2a_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output cnt_t             count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    cnt_t             cnt_q, cnt_d;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/b2a_arith_out_n3.sv
// Output stage of the 3-share B2A converter: aligns arithmetic shares
// with the unmasked z and emits (z - sum(a_i), a1..a(N-1)).
module b2a_arith_out_n3 #(
    parameter int K_WIDTH   = b2a_pkg::K_WIDTH,
    parameter int N_SHARES  = b2a_pkg::N_SHARES,
    parameter int MASKWIDTH = K_WIDTH*N_SHARES,
    parameter int DEPTH     = b2a_pkg::DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            dvld,
    input  logic                            ena,
    input  logic [K_WIDTH*(N_SHARES-1)-1:0] i_a,
    input  logic [K_WIDTH-1:0]              i_z,
    input  logic                            i_zvld,
    output logic [MASKWIDTH-1:0]            o_a,
    output logic                            o_vld,
    input  logic                            i_rdy,
    output logic                            o_stall,
    output logic                            o_err
);

    import b2a_pkg::*;

    localparam int   AW       = K_WIDTH*(N_SHARES-1);
    localparam cnt_t OCC_FULL = cnt_t'(DEPTH);

    logic [AW-1:0]      a_head;
    logic [K_WIDTH-1:0] s0;
    cnt_t               a_cnt, o_cnt, occ;
    logic               a_empty, o_empty;
    logic               a_push, a_pop, o_pop;
    logic               stall;
    logic               err_q, err_d;

    // Stall looks only at registered counts, so a same-cycle drain
    // does not reopen the input until the following cycle.
    assign occ   = a_cnt + o_cnt;
    assign stall = (occ == OCC_FULL);

    assign a_push = dvld & ena & ~stall;
    assign a_pop  = i_zvld & ena & ~a_empty;
    assign o_pop  = ~o_empty & i_rdy;

    always_comb begin
        s0 = i_z;
        for (int i = 0; i < N_SHARES-1; i++) begin
            s0 = s0 - a_head[i*K_WIDTH +: K_WIDTH];
        end
    end

    always_comb begin
        err_d = err_q;
        if (dvld & ena & stall)     err_d = 1'b1;
        if (i_zvld & ena & a_empty) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    b2a_fifo2 #(.WIDTH(AW)) u_afifo (
        .clk   (clk),
        .rst   (rst),
        .push  (a_push),
        .pop   (a_pop),
        .wdata (i_a),
        .rdata (a_head),
        .count (a_cnt),
        .empty (a_empty)
    );

    b2a_fifo2 #(.WIDTH(MASKWIDTH)) u_obuf (
        .clk   (clk),
        .rst   (rst),
        .push  (a_pop),
        .pop   (o_pop),
        .wdata ({a_head, s0}),
        .rdata (o_a),
        .count (o_cnt),
        .empty (o_empty)
    );

    assign o_vld   = ~o_empty;
    assign o_stall = stall;
    assign o_err   = err_q;

endmodule

// File: tb/tb_b2a_arith_out_n3.sv
// Directed self-checking bench for b2a_arith_out_n3.
module tb_b2a_arith_out_n3;
    import b2a_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dvld = 1'b0;
    logic        ena = 1'b0;
    logic [63:0] i_a = '0;
    logic [31:0] i_z = '0;
    logic        i_zvld = 1'b0;
    logic [95:0] o_a;
    logic        o_vld;
    logic        i_rdy = 1'b0;
    logic        o_stall;
    logic        o_err;

    int tests = 0;
    int fails = 0;

    b2a_arith_out_n3 dut (
        .clk     (clk),
        .rst     (rst),
        .dvld    (dvld),
        .ena     (ena),
        .i_a     (i_a),
        .i_z     (i_z),
        .i_zvld  (i_zvld),
        .o_a     (o_a),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_stall (o_stall),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dvld   = 1'b0;
        i_zvld = 1'b0;
        i_a    = '0;
        i_z    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ena = 1'b1;
        i_rdy = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL rst_vld: got %0b exp 0", o_vld); end
        tests++; if (o_a !== 96'h0) begin fails++; $display("FAIL rst_oa: got %h exp 0", o_a); end
        tests++; if (o_stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %0b exp 0", o_stall); end
        tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %0b exp 0", o_err); end
        do_reset();
    endtask

    task automatic test_basic();
        dvld = 1'b1; i_a = {32'h1, 32'h3};
        tick();
        tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL basic_early: got %0b exp 0", o_vld); end
        dvld = 1'b0; i_zvld = 1'b1; i_z = 32'h5;
        tick();
        i_zvld = 1'b0;
        tests++; if (o_vld !== 1'b1) begin fails++; $display("FAIL basic_vld: got %0b exp 1", o_vld); end
        tests++; if (o_a !== {32'h1, 32'h3, 32'h1}) begin fails++; $display("FAIL basic_oa: got %h exp %h", o_a, {32'h1, 32'h3, 32'h1}); end
        tick();
        tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL basic_pulse: got %0b exp 0", o_vld); end
    endtask

    task automatic test_wrap();
        dvld = 1'b1; i_a = {32'h0, 32'h1};
        tick();
        i_a = {32'h80000000, 32'h80000000};
        i_zvld = 1'b1; i_z = 32'h0;
        tick();
        tests++; if (o_a !== {32'h0, 32'h1, 32'hFFFFFFFF}) begin fails++; $display("FAIL wrap_neg: got %h", o_a); end
        tests++; if (o_stall !== 1'b1) begin fails++; $display("FAIL wrap_stall: got %0b exp 1", o_stall); end
        dvld = 1'b0;
        tick();
        i_zvld = 1'b0;
        tests++; if (o_vld !== 1'b1) begin fails++; $display("FAIL wrap_vld2: got %0b exp 1", o_vld); end
        tests++; if (o_a !== {32'h80000000, 32'h80000000, 32'h0}) begin fails++; $display("FAIL wrap_zero: got %h", o_a); end
        tests++; if (o_stall !== 1'b0) begin fails++; $display("FAIL wrap_unstall: got %0b exp 0", o_stall); end
        tick();
        tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL wrap_drain: got %0b exp 0", o_vld); end
    endtask

    task automatic test_back_to_back();
        i_rdy = 1'b0;
        dvld = 1'b1; i_a = {32'd20, 32'd10};
        tick();
        i_a = {32'h2, 32'hFFFFFFFF};
        i_zvld = 1'b1; i_z = 32'd100;
        tick();
        tests++; if (o_stall !== 1'b1) begin fails++; $display("FAIL bp_stall: got %0b exp 1", o_stall); end
        tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL bp_err_pre: got %0b exp 0", o_err); end
        i_a = {32'h77, 32'h66};
        i_z = 32'h10;
        tick();
        dvld = 1'b0; i_zvld = 1'b0;
        tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL bp_err: got %0b exp 1", o_err); end
        tests++; if (o_stall !== 1'b1) begin fails++; $display("FAIL bp_stall2: got %0b exp 1", o_stall); end
        tick();
        tests++; if (o_a !== {32'd20, 32'd10, 32'd70}) begin fails++; $display("FAIL bp_hold: got %h", o_a); end
        i_rdy = 1'b1;
        #1;
        tests++; if (o_stall !== 1'b1) begin fails++; $display("FAIL bp_stall_same: got %0b exp 1", o_stall); end
        tick();
        tests++; if (o_stall !== 1'b0) begin fails++; $display("FAIL bp_stall_fall: got %0b exp 0", o_stall); end
        tests++; if (o_a !== {32'h2, 32'hFFFFFFFF, 32'hF}) begin fails++; $display("FAIL bp_second: got %h", o_a); end
        tick();
        tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL bp_dropped: got %0b exp 0", o_vld); end
    endtask

    task automatic test_orphan();
        do_reset();
        ena = 1'b0; i_zvld = 1'b1;
        tick();
        tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL orphan_ena0: got %0b exp 0", o_err); end
        ena = 1'b1;
        tick();
        i_zvld = 1'b0;
        tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL orphan_err: got %0b exp 1", o_err); end
        tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL orphan_vld: got %0b exp 0", o_vld); end
        tick();
        tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL orphan_vld2: got %0b exp 0", o_vld); end
    endtask

    task automatic test_freeze();
        do_reset();
        i_rdy = 1'b0;
        dvld = 1'b1; i_a = {32'd2, 32'd1};
        tick();
        i_a = {32'd4, 32'd3};
        i_zvld = 1'b1; i_z = 32'd10;
        tick();
        dvld = 1'b0;
        tests++; if (o_a !== {32'd2, 32'd1, 32'd7}) begin fails++; $display("FAIL frz_first: got %h", o_a); end
        ena = 1'b0; i_rdy = 1'b1; i_z = 32'd100;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL frz_idle%0d: got %0b exp 0", c, o_vld); end
        end
        ena = 1'b1;
        tick();
        i_zvld = 1'b0;
        tests++; if (o_vld !== 1'b1) begin fails++; $display("FAIL frz_vld: got %0b exp 1", o_vld); end
        tests++; if (o_a !== {32'd4, 32'd3, 32'd93}) begin fails++; $display("FAIL frz_oa: got %h", o_a); end
        tick();
        tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL frz_drain: got %0b exp 0", o_vld); end
        tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL frz_err: got %0b exp 0", o_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_rdy = 1'b0;
        dvld = 1'b1; i_a = {32'd8, 32'd9};
        tick();
        i_a = {32'd11, 32'd12};
        i_zvld = 1'b1; i_z = 32'd50;
        tick();
        idle_inputs();
        tests++; if (o_vld !== 1'b1) begin fails++; $display("FAIL mid_pre: got %0b exp 1", o_vld); end
        rst = 1'b1;
        #1;
        tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL mid_vld: got %0b exp 0", o_vld); end
        tests++; if (o_a !== 96'h0) begin fails++; $display("FAIL mid_oa: got %h exp 0", o_a); end
        tests++; if (o_stall !== 1'b0) begin fails++; $display("FAIL mid_stall: got %0b exp 0", o_stall); end
        tick();
        rst = 1'b0; i_rdy = 1'b1;
        tick();
        dvld = 1'b1; i_a = {32'd6, 32'd5};
        tick();
        dvld = 1'b0; i_zvld = 1'b1; i_z = 32'd20;
        tick();
        i_zvld = 1'b0;
        tests++; if (o_a !== {32'd6, 32'd5, 32'd9}) begin fails++; $display("FAIL mid_fresh: got %h", o_a); end
        tests++; if (o_vld !== 1'b1) begin fails++; $display("FAIL mid_fvld: got %0b exp 1", o_vld); end
        tick();
        tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL mid_stale: got %0b exp 0", o_vld); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_orphan();
        test_freeze();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
